alu_arbiter: RTL

Shares the single set of floating-point units (multiplier, adder, divider, exponent) among NUM_REQ term-evaluation requesters. Round-robin grant, one operation in flight at a time: latches opcode and operands, pulses the matching unit start, waits for that unit's data_ready (with timeout), and returns the result to the granted requester. Sits between the term accumulators and the FP units.

---
 rtl/alu_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one set of FP units (mult, add/sub, div, exp)
// among NUM_REQ requesters, with one operation in flight at a time.
module alu_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [3*NUM_REQ-1:0]          req_opcode,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_a,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_b,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_error,
    output logic                          mult_start,
    output logic                          add_start,
    output logic                          divide_start,
    output logic                          exponent_start,
    output logic [DATA_WIDTH-1:0]         operand_a,
    output logic [DATA_WIDTH-1:0]         operand_b,
    input  logic [DATA_WIDTH-1:0]         mult_result,
    input  logic [DATA_WIDTH-1:0]         add_result,
    input  logic [DATA_WIDTH-1:0]         divide_result,
    input  logic [DATA_WIDTH-1:0]         exponent_result,
    input  logic                          mult_data_ready,
    input  logic                          add_data_ready,
    input  logic                          divide_data_ready,
    input  logic                          exponent_data_ready,
    output logic [1:0]                    fsm_state
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] OP_EXP  = 3'b000;
    localparam logic [2:0] OP_DIV  = 3'b001;
    localparam logic [2:0] OP_MULT = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_id;
    logic [2:0]      op_q;
    logic [CNT_W-1:0] count;

    logic            found;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] cand_id;
    logic [2:0]      pick_op;
    logic [DATA_WIDTH-1:0] pick_a;
    logic [DATA_WIDTH-1:0] pick_b;
    logic            sel_ready;
    logic [DATA_WIDTH-1:0] sel_result;

    assign fsm_state = state;

    // Handshake: a requester holds req_valid until its one-cycle req_ack, then
    // drops it; its result comes back later as a one-cycle resp_valid pulse.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        cand_id = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_id = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req_valid[cand_id]) begin
                found = 1'b1;
                pick  = cand_id;
            end
        end
    end

    assign pick_op = req_opcode[3*pick +: 3];
    assign pick_a  = req_operand_a[DATA_WIDTH*pick +: DATA_WIDTH];
    assign pick_b  = req_operand_b[DATA_WIDTH*pick +: DATA_WIDTH];

    // Only the unit that was started may complete the operation.
    always_comb begin
        sel_ready  = 1'b0;
        sel_result = '0;
        case (op_q)
            OP_EXP:         begin sel_ready = exponent_data_ready; sel_result = exponent_result; end
            OP_DIV:         begin sel_ready = divide_data_ready;   sel_result = divide_result;   end
            OP_MULT:        begin sel_ready = mult_data_ready;     sel_result = mult_result;     end
            OP_ADD, OP_SUB: begin sel_ready = add_data_ready;      sel_result = add_result;      end
            default:        ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            last_grant     <= ID_W'(NUM_REQ - 1);
            grant_id       <= '0;
            op_q           <= '0;
            count          <= '0;
            req_ack        <= '0;
            resp_valid     <= '0;
            resp_data      <= '0;
            resp_error     <= 1'b0;
            mult_start     <= 1'b0;
            add_start      <= 1'b0;
            divide_start   <= 1'b0;
            exponent_start <= 1'b0;
            operand_a      <= '0;
            operand_b      <= '0;
        end else begin
            req_ack        <= '0;
            resp_valid     <= '0;
            mult_start     <= 1'b0;
            add_start      <= 1'b0;
            divide_start   <= 1'b0;
            exponent_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id       <= pick;
                        op_q           <= pick_op;
                        operand_a      <= pick_a;
                        // Subtraction reuses the adder with b negated.
                        operand_b      <= (pick_op == OP_SUB) ?
                                          {~pick_b[DATA_WIDTH-1], pick_b[DATA_WIDTH-2:0]} : pick_b;
                        req_ack[pick]  <= 1'b1;
                        mult_start     <= (pick_op == OP_MULT);
                        add_start      <= (pick_op == OP_ADD) || (pick_op == OP_SUB);
                        divide_start   <= (pick_op == OP_DIV);
                        exponent_start <= (pick_op == OP_EXP);
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    count <= '0;
                    if (op_q > OP_SUB) begin
                        resp_data            <= '0;
                        resp_error           <= 1'b1;
                        resp_valid[grant_id] <= 1'b1;
                        state                <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (sel_ready) begin
                        resp_data            <= sel_result;
                        resp_error           <= 1'b0;
                        resp_valid[grant_id] <= 1'b1;
                        state                <= RESP;
                    end else if (count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_data            <= '0;
                        resp_error           <= 1'b1;
                        resp_valid[grant_id] <= 1'b1;
                        state                <= RESP;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                RESP: begin
                    last_grant <= grant_id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
